// File: rtl/sap_display_pkg.sv
// Shared types and seven-segment constants for the SAP-1 output display.
// Segment bit order throughout is {a,b,c,d,e,f,g}, lit = 1.
package sap_display_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sap_output_display_if.sv
// W-bus load port and display outputs of the SAP-1 output stage.
interface sap_output_display_if;
  logic [7:0] w_bus;
  logic       load_out;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       value_valid;

  modport master (output w_bus, load_out, input seg, an, busy, value_valid);
  modport slave  (input w_bus, load_out, output seg, an, busy, value_valid);
endinterface

// File: rtl/sap_bin2bcd.sv
// Sequential 8-step double-dabble: start loads bin, then one shift per cycle.
// done is high during the cycle whose edge performs the final shift.
module sap_bin2bcd (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);
  import sap_display_pkg::*;

  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d, adj;
  logic [2:0]  step_q, step_d;
  logic        run_q, run_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    step_d = step_q;
    run_d  = run_q;
    adj    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      step_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
      step_d         = step_q + 3'd1;
      if (step_q == 3'd7) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

  assign done     = run_q && (step_q == 3'd7);
  assign hundreds = bcd_q[11:8];
  assign tens     = bcd_q[7:4];
  assign units    = bcd_q[3:0];

endmodule

// File: rtl/sap_output_display.sv
// SAP-1 output register consumer: capture on load_out low, BCD convert, scan 4 digits.
// Define SAP_SIGNED_DISPLAY_EN to show bytes as two's complement with a '-' sign digit.
module sap_output_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  sap_output_display_if.slave bus
);
  import sap_display_pkg::*;

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic        busy_q, busy_d;
  logic        vv_q, vv_d;
  logic [3:0]  hun_q, hun_d, ten_q, ten_d, uni_q, uni_d;
  logic        blank_h_q, blank_h_d, blank_t_q, blank_t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d, seg_raw;
  logic [3:0]  an_q, an_d, an_raw;
  logic        show, sign_on;

  logic        load, start, core_done;
  logic [7:0]  start_byte, core_bin;
  logic [3:0]  core_h, core_t, core_u;

`ifdef SAP_SIGNED_DISPLAY_EN
  logic neg_cap_q, neg_cap_d, neg_q, neg_d;
  assign core_bin = start_byte[7] ? (~start_byte + 8'd1) : start_byte;
  assign sign_on  = neg_q;
`else
  assign core_bin = start_byte;
  assign sign_on  = 1'b0;
`endif

  assign load = !bus.load_out;

  sap_bin2bcd u_bcd (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin      (core_bin),
    .done     (core_done),
    .hundreds (core_h),
    .tens     (core_t),
    .units    (core_u)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    busy_d      = busy_q;
    vv_d        = vv_q;
    hun_d       = hun_q;
    ten_d       = ten_q;
    uni_d       = uni_q;
    blank_h_d   = blank_h_q;
    blank_t_d   = blank_t_q;
    start       = 1'b0;
    start_byte  = bus.w_bus;
`ifdef SAP_SIGNED_DISPLAY_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      IDLE: begin
        // A fresh load beats a leftover pending byte: it is the newer value.
        if (load || pend_q) begin
          start      = 1'b1;
          start_byte = load ? bus.w_bus : pend_byte_q;
          pend_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        if (load) begin
          pend_d      = 1'b1;
          pend_byte_d = bus.w_bus;
        end
        if (core_done) state_d = DONE;
      end
      DONE: begin
        hun_d     = core_h;
        ten_d     = core_t;
        uni_d     = core_u;
        blank_h_d = (core_h == 4'd0);
        blank_t_d = (core_h == 4'd0) && (core_t == 4'd0);
        vv_d      = 1'b1;
`ifdef SAP_SIGNED_DISPLAY_EN
        neg_d     = neg_cap_q;
`endif
        if (pend_q) begin
          start      = 1'b1;
          start_byte = pend_byte_q;
          pend_d     = 1'b0;
          state_d    = CONVERT;
        end else begin
          state_d    = IDLE;
        end
        busy_d = pend_q || load;
        if (load) begin
          pend_d      = 1'b1;
          pend_byte_d = bus.w_bus;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SAP_SIGNED_DISPLAY_EN
  assign neg_cap_d = start ? start_byte[7] : neg_cap_q;
`endif

  // Scan: the digit shown this cycle is registered, so outputs lag idx by one clock.
  always_comb begin
    cnt_d = (cnt_q == CW'(REFRESH_DIV - 1)) ? '0 : cnt_q + 1'b1;
    idx_d = (cnt_q == CW'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
    case (idx_q)
      2'd0:    begin seg_raw = seg_of(uni_q); show = 1'b1;       end
      2'd1:    begin seg_raw = seg_of(ten_q); show = !blank_t_q; end
      2'd2:    begin seg_raw = seg_of(hun_q); show = !blank_h_q; end
      default: begin seg_raw = SEG_MINUS;     show = sign_on;    end
    endcase
    show   = show && vv_q;
    an_raw = show ? (4'b0001 << idx_q) : 4'b0000;
    if (!show) seg_raw = SEG_BLANK;
    seg_d  = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d   = SEG_ACTIVE_LOW ? ~an_raw : an_raw;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      busy_q      <= 1'b0;
      vv_q        <= 1'b0;
      hun_q       <= '0;
      ten_q       <= '0;
      uni_q       <= '0;
      blank_h_q   <= 1'b1;
      blank_t_q   <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= {7{SEG_ACTIVE_LOW}};
      an_q        <= {4{SEG_ACTIVE_LOW}};
`ifdef SAP_SIGNED_DISPLAY_EN
      neg_cap_q   <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      busy_q      <= busy_d;
      vv_q        <= vv_d;
      hun_q       <= hun_d;
      ten_q       <= ten_d;
      uni_q       <= uni_d;
      blank_h_q   <= blank_h_d;
      blank_t_q   <= blank_t_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
`ifdef SAP_SIGNED_DISPLAY_EN
      neg_cap_q   <= neg_cap_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.busy        = busy_q;
  assign bus.value_valid = vv_q;

endmodule

// File: doc/sap_output_display.md
Name: sap_output_display

Overview:
- Downstream consumer of the SAP-1 output register path.
- Captures the W-bus byte when the controller asserts load_out (active-low, as in the control word).
- Converts the byte to BCD with a sequential 8-step double-dabble, with leading-zero blanking.
- Drives a 4-digit multiplexed seven-segment display for the board.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled before the scan advances; minimum 2.
- SEG_ACTIVE_LOW, 1: when 1, seg and an outputs are active-low; when 0, active-high.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- w_bus  input  8  SAP W bus.
- load_out  input  1  active-low output-load strobe from the control word; sampled on posedge.
- seg  output  7  segments; seg[6]=a … seg[0]=g.
- an  output  4  digit enables; an[0]=units, an[1]=tens, an[2]=hundreds, an[3]=sign.
- busy  output  1  high while a conversion is in progress.
- value_valid  output  1  high once the first conversion has completed; sticky until reset.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; pending flag, shift registers and refresh counter cleared; scan index = 0.
  - Display digit registers = 0, blank mask = hundreds and tens blanked.
  - busy = 0, value_valid = 0.
  - All an outputs inactive while value_valid = 0, so the display is dark until the first load.
- FSM states: IDLE, CONVERT, DONE.
  - IDLE: on a posedge with load_out = 0, capture w_bus into the shift register, clear the BCD accumulator and step count, go to CONVERT.
  - CONVERT: on each cycle, add 3 to every BCD nibble >= 5, then shift left by 1 with the binary MSB entering the BCD LSB. After exactly 8 steps, go to DONE.
  - DONE:
    - Copy hundreds/tens/units into the display registers atomically.
    - Compute the blank mask: hundreds blanked if 0; tens blanked if hundreds and tens are both 0; units never blanked.
    - Set value_valid.
    - Go to CONVERT if pending is set (consuming it), else go to IDLE.
- Latency:
  - Capture edge E0.
  - Display reflects the new value from edge E9 onward.
  - busy = 1 after E0 through E9; busy = 0 after E9 unless a pending load restarts conversion.
- Load during CONVERT or DONE:
  - The byte is stored in a one-deep pending register and the pending flag is set.
  - A later load before the flag is consumed overwrites the pending byte (last value wins).
  - The in-flight conversion is never disturbed.
- Load on the same edge the pending byte is consumed: the new byte becomes the pending byte.
- Reset mid-conversion: the conversion is abandoned and any pending byte is discarded.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1; on wrap, the scan index advances 0→1→2→3→0.
  - Exactly one an is active at a time, and only when value_valid = 1.
  - A digit that is blanked, or the sign digit with nothing to show, keeps its an inactive.
- Segment encoding: standard hex 0–9 patterns; the active level is set by SEG_ACTIVE_LOW.
- All outputs are registered.

Optional Feature:
- Macro SAP_SIGNED_DISPLAY_EN.
- Defined:
  - The captured byte is treated as two's complement.
  - If bit 7 = 1, the magnitude (0 – value, taken as 8-bit unsigned, so -128 → 128) is converted and a neg flag is latched at DONE.
  - When neg = 1, the sign digit (an[3]) shows '-' (segment g only); the sign digit is inactive when neg = 0.
- Undefined:
  - The byte is unsigned (0–255) and an[3] is never active.
  - No neg logic is synthesised.

Decomposition:
- Package sap_display_pkg: the FSM state enum {IDLE, CONVERT, DONE}, the 7-bit segment constants for digits 0–9, the MINUS pattern, and a digit-index typedef (2 bits).
- Sub-module sap_bin2bcd: the sequential double-dabble core with start/done handshake.
  - Interface: clock, reset, start, bin[7:0] in; done, hundreds, tens, units out.
  - The top module holds the capture/pending logic, the display registers, and the scan.

Test Plan (REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
- Reset, no loads → an = 4'b1111 permanently, value_valid = 0, busy = 0.
- w_bus=8'd255, load_out=0 for 1 cycle → busy high 9 cycles; scan shows units 5, tens 5, hundreds 2; an[3] never low.
- w_bus=8'd7 → only an[0] goes low, seg = pattern 7; an[1], an[2] stay high.
- Load 8'd42, then 8'd100 and 8'd200 at E3 and E5 → display 42 at E9, then 200 at E18; 100 is never displayed.
- Load 8'd99, assert reset at E4, release, wait 20 cycles → display dark, value_valid = 0.
- SAP_SIGNED_DISPLAY_EN defined:
  - Load 8'h80 → 128 with '-' on an[3].
  - Load 8'hFF → 1 with '-'.
  - Load 8'h05 → 5 with an[3] inactive.
